// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/interlock unit: address width default,
// forwarding-select width, the NOP instruction word and the scoreboard entry layout.
package pipe_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int FWD_SEL_W  = 3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Scoreboard entry, LSB first: ld, da[ADDR_W-1:0], rw, v  (i.e. {v, rw, da, ld})
    localparam int SB_LD_OFS = 0;
    localparam int SB_DA_OFS = 1;

    function automatic int sb_rw_ofs(input int addr_w);
        return SB_DA_OFS + addr_w;
    endfunction

    function automatic int sb_v_ofs(input int addr_w);
        return SB_DA_OFS + addr_w + 1;
    endfunction

    function automatic int sb_entry_w(input int addr_w);
        return addr_w + 3;
    endfunction

endpackage

// File: rtl/sb_match.sv
// Compares one scoreboard entry against one decode source address and flags a RAW hit.
module sb_match
    import pipe_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit REG0_HW = 1'b1,
    parameter bit MASKED  = 1'b0
) (
    input  logic              v,
    input  logic              rw,
    input  logic [ADDR_W-1:0] da,
    input  logic [ADDR_W-1:0] addr,
    input  logic              use_src,
    output logic              hit
);

    // MASKED marks the write-back stage when the register file writes before it reads.
    assign hit = v & rw & use_src & (da == addr)
               & ~(REG0_HW & (addr == '0))
               & ~MASKED;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/interlock unit: in-flight writer scoreboard, RAW stall, branch flush and counters.
// Define FWD_HAZ_EN to enable forwarding selects (only load-use hazards then stall).
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DEPTH     = 2,
    parameter int WB_BYPASS = 1,
    parameter int REG0_HW   = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [ADDR_W-1:0]    id_aa,
    input  logic [ADDR_W-1:0]    id_ba,
    input  logic                 id_use_a,
    input  logic                 id_use_b,
    input  logic                 id_rw,
    input  logic [ADDR_W-1:0]    id_da,
    input  logic                 id_load,
    input  logic                 br_taken,
    output logic                 hold_pc,
    output logic                 flush_id,
    output logic                 bubble_ex,
    output logic [FWD_SEL_W-1:0] fwd_a_sel,
    output logic [FWD_SEL_W-1:0] fwd_b_sel,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int ENTRY_W = sb_entry_w(ADDR_W);
    localparam int RW_BIT  = sb_rw_ofs(ADDR_W);
    localparam int V_BIT   = sb_v_ofs(ADDR_W);

    logic [ENTRY_W-1:0] sb [1:DEPTH];
    logic [DEPTH:1]     hit_a;
    logic [DEPTH:1]     hit_b;
    logic [DEPTH:1]     ld_vec;
    logic               stall;
    logic               admit;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        localparam bit MASKED = (WB_BYPASS != 0) && (k == DEPTH);

        assign ld_vec[k] = sb[k][SB_LD_OFS];

        sb_match #(.ADDR_W(ADDR_W), .REG0_HW(REG0_HW != 0), .MASKED(MASKED)) u_match_a (
            .v       (sb[k][V_BIT]),
            .rw      (sb[k][RW_BIT]),
            .da      (sb[k][SB_DA_OFS +: ADDR_W]),
            .addr    (id_aa),
            .use_src (id_use_a),
            .hit     (hit_a[k])
        );

        sb_match #(.ADDR_W(ADDR_W), .REG0_HW(REG0_HW != 0), .MASKED(MASKED)) u_match_b (
            .v       (sb[k][V_BIT]),
            .rw      (sb[k][RW_BIT]),
            .da      (sb[k][SB_DA_OFS +: ADDR_W]),
            .addr    (id_ba),
            .use_src (id_use_b),
            .hit     (hit_b[k])
        );
    end

`ifdef FWD_HAZ_EN
    logic [DEPTH:1] load_use;

    // Youngest forwardable producer; a load only has data once it reaches stage DEPTH.
    function automatic logic [FWD_SEL_W-1:0] pick_src(input logic [DEPTH:1] hit,
                                                      input logic [DEPTH:1] ld);
        pick_src = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit[k] && (!ld[k] || k == DEPTH))
                pick_src = FWD_SEL_W'(k);
        end
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        load_use = '0;
        for (int k = 1; k < DEPTH; k++)
            load_use[k] = (hit_a[k] | hit_b[k]) & ld_vec[k];
    end

    assign stall     = id_valid & (|load_use);
    assign fwd_a_sel = (rst || !id_valid) ? '0 : pick_src(hit_a, ld_vec);
    assign fwd_b_sel = (rst || !id_valid) ? '0 : pick_src(hit_b, ld_vec);
`else
    logic unused_ld;

    assign unused_ld = ^ld_vec;
    assign stall     = id_valid & (|(hit_a | hit_b));
    assign fwd_a_sel = '0;
    assign fwd_b_sel = '0;
`endif

    // A taken branch squashes decode, so it overrides the hold and nothing is replayed.
    assign hold_pc   = ~rst & stall & ~br_taken;
    assign bubble_ex = ~rst & (stall | br_taken);
    assign flush_id  = ~rst & br_taken;
    assign admit     = id_valid & ~stall & ~br_taken;

    // NOTE: the scoreboard array is reset explicitly because stale valid bits would raise false hazards.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++)
                sb[k] <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            sb[1] <= admit ? {1'b1, id_rw, id_da, id_load} : '0;
            for (int k = 2; k <= DEPTH; k++)
                sb[k] <= sb[k-1];
            if (hold_pc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_taken && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, multi-cycle sequences and a randomized run
// against an in-flight-writer model; two configurations share the same stimulus.
module tb_pipe_hazard_ctrl;

`ifdef FWD_HAZ_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int NCFG    = 2;
    localparam int M_DEPTH = 2;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       ld;
        logic [4:0] da;
    } ent_t;

    typedef struct packed {
        logic       stall;
        logic       hold;
        logic       flush;
        logic       bubble;
        logic [2:0] fa;
        logic [2:0] fb;
    } exp_t;

    typedef struct packed {
        int valid, aa, ba, ua, ub, rw, da, ld, br;
        int hold, flush, bubble, fa, sc, fc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_a, id_use_b, id_rw, id_load, br_taken;
    logic [4:0] id_aa, id_ba, id_da;
    logic       d_hold   [NCFG];
    logic       d_flush  [NCFG];
    logic       d_bubble [NCFG];
    logic [2:0] d_fa     [NCFG];
    logic [2:0] d_fb     [NCFG];
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    ent_t m_pipe [NCFG][M_DEPTH];
    int   m_sc   [NCFG];
    int   m_fc   [NCFG];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ADDR_W(5), .DEPTH(2), .WB_BYPASS(1), .REG0_HW(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_aa(id_aa), .id_ba(id_ba),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rw(id_rw), .id_da(id_da),
        .id_load(id_load), .br_taken(br_taken), .hold_pc(d_hold[0]), .flush_id(d_flush[0]),
        .bubble_ex(d_bubble[0]), .fwd_a_sel(d_fa[0]), .fwd_b_sel(d_fb[0]),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    pipe_hazard_ctrl #(.ADDR_W(5), .DEPTH(2), .WB_BYPASS(0), .REG0_HW(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_aa(id_aa), .id_ba(id_ba),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rw(id_rw), .id_da(id_da),
        .id_load(id_load), .br_taken(br_taken), .hold_pc(d_hold[1]), .flush_id(d_flush[1]),
        .bubble_ex(d_bubble[1]), .fwd_a_sel(d_fa[1]), .fwd_b_sel(d_fb[1]),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    function automatic bit wbb_of(input int c);
        return c == 0;
    endfunction

    function automatic int max_of(input int c);
        return (c == 0) ? 65535 : 15;
    endfunction

    task automatic check(input string name, input longint act, input longint want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Expected outputs from the list of in-flight writers, youngest first.
    function automatic exp_t model_eval(input int c);
        exp_t e;
        e = '0;
        if (rst !== 1'b0) return e;
        for (int age = 1; age <= M_DEPTH; age++) begin
            ent_t w;
            bit   visible, ra, rb, ready;
            w       = m_pipe[c][age-1];
            visible = w.v && w.rw && !(wbb_of(c) && age == M_DEPTH);
            ra      = visible && id_use_a && id_aa != 0 && w.da == id_aa;
            rb      = visible && id_use_b && id_ba != 0 && w.da == id_ba;
            ready   = !w.ld || age == M_DEPTH;
            if ((ra || rb) && !(FWD && ready)) e.stall = 1'b1;
            if (FWD && ra && ready && e.fa == 0) e.fa = 3'(age);
            if (FWD && rb && ready && e.fb == 0) e.fb = 3'(age);
        end
        if (!id_valid) begin
            e.stall = 1'b0;
            e.fa    = '0;
            e.fb    = '0;
        end
        e.hold   = e.stall && !br_taken;
        e.flush  = br_taken;
        e.bubble = e.stall || br_taken;
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            for (int a = 0; a < M_DEPTH; a++) m_pipe[c][a] = '0;
            m_sc[c] = 0;
            m_fc[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCFG; c++) begin
            exp_t e;
            ent_t n;
            e = model_eval(c);
            if (e.hold && m_sc[c] < max_of(c)) m_sc[c]++;
            if (br_taken && m_fc[c] < max_of(c)) m_fc[c]++;
            for (int a = M_DEPTH - 1; a >= 1; a--) m_pipe[c][a] = m_pipe[c][a-1];
            n = '0;
            if (id_valid && !e.stall && !br_taken) begin
                n.v  = 1'b1;
                n.rw = id_rw;
                n.ld = id_load;
                n.da = id_da;
            end
            m_pipe[c][0] = n;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCFG; c++) begin
            exp_t e;
            e = model_eval(c);
            check($sformatf("cfg%0d hold_pc", c), d_hold[c], e.hold);
            check($sformatf("cfg%0d flush_id", c), d_flush[c], e.flush);
            check($sformatf("cfg%0d bubble_ex", c), d_bubble[c], e.bubble);
            check($sformatf("cfg%0d fwd_a_sel", c), d_fa[c], e.fa);
            check($sformatf("cfg%0d fwd_b_sel", c), d_fb[c], e.fb);
            check($sformatf("cfg%0d stall_cnt", c), (c == 0) ? sc0 : 16'(sc1), m_sc[c]);
            check($sformatf("cfg%0d flush_cnt", c), (c == 0) ? fc0 : 16'(fc1), m_fc[c]);
        end
    endtask

    task automatic drive(input int valid, input int aa, input int ba, input int ua,
                         input int ub, input int rw, input int da, input int ld, input int br);
        id_valid = 1'(valid);
        id_aa    = 5'(aa);
        id_ba    = 5'(ba);
        id_use_a = 1'(ua);
        id_use_b = 1'(ub);
        id_rw    = 1'(rw);
        id_da    = 5'(da);
        id_load  = 1'(ld);
        br_taken = 1'(br);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called at the posedge: compare, advance the model, then move to just after the negedge.
    task automatic finish_cycle();
        check_all();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        finish_cycle();
    endtask

    function automatic vec_t mk(input int valid, aa, ba, ua, ub, rw, da, ld, br,
                                input int hold, flush, bubble, fa, sc, fc);
        vec_t v;
        v = '{valid, aa, ba, ua, ub, rw, da, ld, br, hold, flush, bubble, fa, sc, fc};
        return v;
    endfunction

    initial begin
        vec_t tbl [12];

        // Consecutive edges on u_dut (DEPTH=2, WB_BYPASS=1) starting from an empty scoreboard.
        tbl[0]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 3, 1, 1, 1, 1, 4, 0, 0,  !FWD, 0, !FWD, FWD ? 1 : 0, 0, 0);
        tbl[2]  = mk(1, 3, 1, 1, 1, 1, 4, 0, 0,  0, 0, 0, 0, FWD ? 0 : 1, 0);
        tbl[3]  = mk(1, 5, 6, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, FWD ? 0 : 1, 0);
        tbl[4]  = mk(1, 0, 0, 1, 1, 1, 9, 0, 0,  0, 0, 0, 0, FWD ? 0 : 1, 0);
        tbl[5]  = mk(1, 9, 2, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, FWD ? 0 : 1, 0);
        tbl[6]  = mk(1, 1, 1, 1, 0, 1, 5, 1, 0,  0, 0, 0, 0, FWD ? 0 : 1, 0);
        tbl[7]  = mk(1, 5, 2, 1, 1, 1, 6, 0, 0,  1, 0, 1, 0, FWD ? 0 : 1, 0);
        tbl[8]  = mk(1, 5, 2, 1, 1, 1, 6, 0, 0,  0, 0, 0, 0, FWD ? 1 : 2, 0);
        tbl[9]  = mk(1, 6, 2, 1, 0, 1, 7, 0, 1,  0, 1, 1, FWD ? 1 : 0, FWD ? 1 : 2, 0);
        tbl[10] = mk(1, 6, 2, 1, 0, 1, 6, 0, 0,  0, 0, 0, 0, FWD ? 1 : 2, 1);
        tbl[11] = mk(0, 6, 6, 1, 1, 1, 6, 0, 0,  0, 0, 0, 0, FWD ? 1 : 2, 1);

        // Reset with busy inputs: every output must stay low.
        rst = 1'b1;
        drive(1, 3, 3, 1, 1, 1, 3, 1, 1);
        model_reset();
        #2;
        check_all();
        check("reset flush_id", d_flush[0], 0);
        check("reset stall_cnt", sc0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle();
        tick();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].valid, tbl[i].aa, tbl[i].ba, tbl[i].ua, tbl[i].ub,
                  tbl[i].rw, tbl[i].da, tbl[i].ld, tbl[i].br);
            @(posedge clk);
            check($sformatf("vec%0d hold_pc", i), d_hold[0], tbl[i].hold);
            check($sformatf("vec%0d flush_id", i), d_flush[0], tbl[i].flush);
            check($sformatf("vec%0d bubble_ex", i), d_bubble[0], tbl[i].bubble);
            check($sformatf("vec%0d fwd_a_sel", i), d_fa[0], tbl[i].fa);
            check($sformatf("vec%0d stall_cnt", i), sc0, tbl[i].sc);
            check($sformatf("vec%0d flush_cnt", i), fc0, tbl[i].fc);
            finish_cycle();
        end

        // Reset in the middle of a load-use stall drops hold_pc at once.
        drive(1, 1, 0, 0, 0, 1, 3, 1, 0);
        tick();
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        check("midstall hold before reset", d_hold[0], 1);
        check("midstall hold before reset cfg1", d_hold[1], 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("midstall hold after reset", d_hold[0], 0);
        check("midstall bubble after reset", d_bubble[0], 0);
        check("midstall hold after reset cfg1", d_hold[1], 0);
        check("midstall stall_cnt cleared", sc0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle();
        repeat (2) tick();

        // ALU producer one ahead: forwarded from stage 1 when enabled, else a stall.
        drive(1, 1, 0, 0, 0, 1, 5, 0, 0);
        tick();
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        check("alu fwd_a_sel", d_fa[0], FWD ? 1 : 0);
        check("alu hold_pc", d_hold[0], FWD ? 0 : 1);
        finish_cycle();
        idle();
        repeat (3) tick();

        // Load-use on u_sat (no write-back bypass): one stall, then forward from stage 2.
        drive(1, 1, 0, 0, 0, 1, 5, 1, 0);
        tick();
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        check("load-use stall", d_hold[1], 1);
        finish_cycle();
        @(posedge clk);
        check("load-use release", d_hold[1], FWD ? 0 : 1);
        check("load-use fwd_a_sel", d_fa[1], FWD ? 2 : 0);
        finish_cycle();
        idle();
        repeat (3) tick();

        // Repeated load-use pairs drive the 4-bit stall counter into saturation.
        repeat (25) begin
            drive(1, 1, 0, 0, 0, 1, 7, 1, 0);
            tick();
            drive(1, 7, 0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        check("saturated stall_cnt", sc1, 15);

        repeat (600) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
